// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Tracks pending register write-backs between decode (issue) and write-back
// (retire). Each architectural register keeps a small count of issued
// instructions that still owe it a write. Decode is stalled when an enabled
// source register still has a write outstanding. Decode is also stalled when
// the destination counter has no room left. The block also keeps a
// saturating stall-cycle counter and a sticky deadlock watchdog.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_valid                   decode presents an instruction
//   reg_rd_en1/2, reg_rd_addr1/2   source operands of that instruction
//   reg_wr_en, reg_wr_addr     destination of that instruction
//   wb_wr_en, wb_wr_addr       register write retired this cycle
//   flush                      cancel every in-flight write
//   id_stall, id_issue         combinational hold / accept for decode
//   busy_vec                   bit i set while register i has pending writes
//   stall_cnt                  saturating total of stall cycles since reset
//   deadlock                   sticky flag after STALL_LIMIT straight stalls
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int REG_NUM     = 32,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 2,
    parameter int STALL_LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               reg_rd_en1,
    input  logic [ADDR_W-1:0]  reg_rd_addr1,
    input  logic               reg_rd_en2,
    input  logic [ADDR_W-1:0]  reg_rd_addr2,
    input  logic               reg_wr_en,
    input  logic [ADDR_W-1:0]  reg_wr_addr,
    input  logic               wb_wr_en,
    input  logic [ADDR_W-1:0]  wb_wr_addr,
    input  logic               flush,
    output logic               id_stall,
    output logic               id_issue,
    output logic [REG_NUM-1:0] busy_vec,
    output logic [31:0]        stall_cnt,
    output logic               deadlock
);

    localparam int              WD_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             deadlock_q, deadlock_d;

    logic [CNT_W-1:0] rd1_cnt, rd2_cnt, wr_cnt;
    logic             src1_haz, src2_haz, dest_haz;

    // Counter lookup is a mux over the tracked registers only. Register 0
    // and any address beyond REG_NUM read as zero, so they never hazard.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves a latch behind.
        rd1_cnt = '0;
        rd2_cnt = '0;
        wr_cnt  = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            if (reg_rd_addr1 == ADDR_W'(i)) rd1_cnt = cnt_q[i];
            if (reg_rd_addr2 == ADDR_W'(i)) rd2_cnt = cnt_q[i];
            if (reg_wr_addr  == ADDR_W'(i)) wr_cnt  = cnt_q[i];
        end
    end

    // A source whose last pending write retires this very cycle is safe,
    // because the register file writes before it reads.
    assign src1_haz = reg_rd_en1 && (rd1_cnt != '0) &&
                      !(wb_wr_en && (wb_wr_addr == reg_rd_addr1) && (rd1_cnt == CNT_ONE));
    assign src2_haz = reg_rd_en2 && (rd2_cnt != '0) &&
                      !(wb_wr_en && (wb_wr_addr == reg_rd_addr2) && (rd2_cnt == CNT_ONE));
    // Saturation is judged on the registered count alone. A retire in the
    // same cycle does not free a slot until the next cycle.
    assign dest_haz = reg_wr_en && (wr_cnt == CNT_MAX);

    assign id_stall = id_valid && !flush && (src1_haz || src2_haz || dest_haz);
    assign id_issue = id_valid && !flush && !id_stall;

    always_comb begin
        logic inc, dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < REG_NUM; i++) cnt_d[i] = cnt_q[i];
        for (int i = 1; i < REG_NUM; i++) begin
            inc = id_issue && reg_wr_en && (reg_wr_addr == ADDR_W'(i));
            dec = wb_wr_en && (wb_wr_addr == ADDR_W'(i)) && (cnt_q[i] != '0);
            if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_ONE;
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
        if (flush) begin
            for (int i = 0; i < REG_NUM; i++) cnt_d[i] = '0;
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        wd_d        = '0;
        deadlock_d  = deadlock_q;
        if (id_stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
            wd_d = (wd_q == WD_W'(STALL_LIMIT)) ? wd_q : wd_q + WD_W'(1);
            // The limit is reached while this stall cycle completes.
            if (wd_q == WD_W'(STALL_LIMIT - 1)) deadlock_d = 1'b1;
        end
        if (flush) deadlock_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counter array is state that decides stalls, not
            // storage for data, so every entry is reset explicitly.
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
            stall_cnt_q <= '0;
            wd_q        <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments only, so
            // every flop samples its next-state value from before the edge.
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= cnt_d[i];
            stall_cnt_q <= stall_cnt_d;
            wd_q        <= wd_d;
            deadlock_q  <= deadlock_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < REG_NUM; i++) busy_vec[i] = (cnt_q[i] != '0);
    end

    assign stall_cnt = stall_cnt_q;
    assign deadlock  = deadlock_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed scenarios followed by random traffic. Every cycle is compared
// against a behavioural model: an integer count per register, a total stall
// count, and a run-length of consecutive stalls.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int MAXC  = 3;   // 2**CNT_W - 1
    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, reg_rd_en1, reg_rd_en2, reg_wr_en, wb_wr_en, flush;
    logic [4:0]  reg_rd_addr1, reg_rd_addr2, reg_wr_addr, wb_wr_addr;
    logic        id_stall, id_issue, deadlock;
    logic [31:0] busy_vec, stall_cnt;

    reg_scoreboard #(.REG_NUM(32), .ADDR_W(5), .CNT_W(2), .STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .reg_rd_en1(reg_rd_en1), .reg_rd_addr1(reg_rd_addr1),
        .reg_rd_en2(reg_rd_en2), .reg_rd_addr2(reg_rd_addr2),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .flush(flush),
        .id_stall(id_stall), .id_issue(id_issue), .busy_vec(busy_vec),
        .stall_cnt(stall_cnt), .deadlock(deadlock)
    );

    always #5 clk = ~clk;

    // Reference model state
    int     mcnt [32];
    longint m_total;
    int     m_consec;
    bit     m_dead;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic obs_stall, obs_issue;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit src_haz(input logic en, input logic [4:0] a);
        return en && a != 0 && mcnt[a] > 0 &&
               !(wb_wr_en && wb_wr_addr == a && mcnt[a] == 1);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (mcnt[i] > 0);
        return b;
    endfunction

    // One clock cycle: drive, check combinational outputs mid-cycle, clock,
    // advance the model, check the registered outputs just after the edge.
    task automatic step(input logic v,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2,
                        input logic we, input logic [4:0] wa,
                        input logic wbe, input logic [4:0] wba,
                        input logic fl, input logic r);
        bit exp_stall, exp_issue;
        id_valid = v; reg_rd_en1 = e1; reg_rd_addr1 = a1;
        reg_rd_en2 = e2; reg_rd_addr2 = a2; reg_wr_en = we; reg_wr_addr = wa;
        wb_wr_en = wbe; wb_wr_addr = wba; flush = fl; rst = r;
        #1;
        exp_stall = v && !fl && (src_haz(e1, a1) || src_haz(e2, a2) ||
                                 (we && wa != 0 && mcnt[wa] == MAXC));
        exp_issue = v && !fl && !exp_stall;
        obs_stall = id_stall;
        obs_issue = id_issue;
        check("id_stall", id_stall, exp_stall);
        check("id_issue", id_issue, exp_issue);
        @(posedge clk);
        if (r) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            m_total = 0; m_consec = 0; m_dead = 0;
        end else begin
            if (fl) begin
                foreach (mcnt[i]) mcnt[i] = 0;
            end else begin
                if (wbe && wba != 0 && mcnt[wba] > 0) mcnt[wba]--;
                if (exp_issue && we && wa != 0) mcnt[wa]++;
            end
            if (exp_stall) begin
                if (m_total < 64'hFFFF_FFFF) m_total++;
                m_consec++;
                if (m_consec >= LIMIT) m_dead = 1;
            end else begin
                m_consec = 0;
            end
            if (fl) m_dead = 0;
        end
        #1;
        check("busy_vec", busy_vec, m_busy());
        check("stall_cnt", stall_cnt, m_total[31:0]);
        check("deadlock", deadlock, m_dead);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (mcnt[i]) mcnt[i] = 0;
        m_total = 0; m_consec = 0; m_dead = 0;
        rst = 1; id_valid = 0; reg_rd_en1 = 0; reg_rd_en2 = 0; reg_wr_en = 0;
        wb_wr_en = 0; flush = 0; reg_rd_addr1 = 0; reg_rd_addr2 = 0;
        reg_wr_addr = 0; wb_wr_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy_vec", busy_vec, 0);
        check("reset stall_cnt", stall_cnt, 0);
        check("reset deadlock", deadlock, 0);
        check("reset id_stall", id_stall, 0);

        // Producer r5, blocked reader, then reader released by same-cycle WB
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        check("r5 busy", busy_vec, 32'h0000_0020);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        check("r5 reader stall", obs_stall, 1);
        step(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
        check("r5 bypass stall", obs_stall, 0);
        check("r5 bypass issue", obs_issue, 1);
        check("r5 drained", busy_vec, 0);

        // Saturate r7, 4th writer waits even with a same-cycle WB
        repeat (3) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        check("r7 busy", busy_vec[7], 1);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        check("r7 sat stall", obs_stall, 1);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
        check("r7 sat+wb stall", obs_stall, 1);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        check("r7 writer issues", obs_issue, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        check("r7 drained", busy_vec, 0);

        // r0 is never tracked; WB to idle r9 is ignored
        step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        check("r0 no stall", obs_stall, 0);
        check("r0 not busy", busy_vec[0], 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        check("r9 no underflow", busy_vec[9], 0);

        // Issue and WB of r3 in one cycle keep the count at 1
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0);
        check("r3 held", busy_vec, 32'h0000_0008);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        check("r3 drained", busy_vec, 0);

        // Watchdog: 64 straight stalls from a fresh reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
        repeat (LIMIT - 1) step(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wd not yet", deadlock, 0);
        step(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wd stall_cnt", stall_cnt, 64);
        check("wd deadlock", deadlock, 1);
        step(1, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0);
        check("flush busy", busy_vec, 0);
        check("flush deadlock", deadlock, 0);
        check("flush stall_cnt", stall_cnt, 64);

        // Reset while r4 has two pending writes and decode is stalled
        repeat (2) step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst stall seen", obs_stall, 1);
        check("rst busy", busy_vec, 0);
        check("rst stall_cnt", stall_cnt, 0);
        check("rst deadlock", deadlock, 0);

        // Random traffic on a small register window to force hazards
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 299) == 0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Pending-write scoreboard and issue-stall controller for the MIPS register file read/write ports driven by the decode stage. It tracks, per architectural register, how many issued instructions still owe a write-back. Decode is stalled while either enabled source register has an outstanding write. It also provides a stall-cycle performance counter and a sticky deadlock watchdog. It sits between the decode stage (issue side) and the write-back stage (retire side).

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (register 0 hard-wired zero, never tracked)
- ADDR_W, 5, register address width
- CNT_W, 2, width of per-register pending-write counter (max in-flight writes per register = 2^CNT_W-1)
- STALL_LIMIT, 64, consecutive stall cycles after which deadlock asserts

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  decode holds a valid instruction this cycle
- reg_rd_en1  in  1  source 1 is read
- reg_rd_addr1  in  ADDR_W  source 1 register
- reg_rd_en2  in  1  source 2 is read
- reg_rd_addr2  in  ADDR_W  source 2 register
- reg_wr_en  in  1  instruction writes a destination
- reg_wr_addr  in  ADDR_W  destination register
- wb_wr_en  in  1  write-back retires a register write this cycle
- wb_wr_addr  in  ADDR_W  register being written back
- flush  in  1  cancel all in-flight instructions
- id_stall  out  1  decode must hold its instruction
- id_issue  out  1  instruction accepted this cycle
- busy_vec  out  REG_NUM  bit i = register i has pending count > 0
- stall_cnt  out  32  total stall cycles since reset, saturating
- deadlock  out  1  sticky watchdog flag

## Operation
- State: cnt[i] (CNT_W bits) for i = 1..REG_NUM-1. cnt[0] is constant 0.
- Source hazard for source k: reg_rd_enk, addr != 0, and cnt[addr] > 0. Same-cycle WB bypass: if wb_wr_en, wb_wr_addr == addr, and cnt[addr] == 1, the source is not hazarded, because the register file writes before it reads.
- Destination hazard: reg_wr_en, reg_wr_addr != 0, and cnt[reg_wr_addr] is saturated (all ones). The WB bypass does not apply to saturation.
- id_stall = id_valid & ~flush & (src1 hazard | src2 hazard | dest hazard).
- id_issue = id_valid & ~flush & ~id_stall.
- Counter update, per register, next cycle:
  - inc = id_issue & reg_wr_en & reg_wr_addr == i.
  - dec = wb_wr_en & wb_wr_addr == i & cnt[i] != 0.
  - inc & dec leaves the count unchanged. inc alone adds 1. dec alone subtracts 1.
  - A WB to a register whose count is 0 is ignored (no underflow).
  - Writes to register 0 are never counted.
- flush: all cnt cleared next cycle. It overrides same-cycle issue and WB.
- stall_cnt: +1 every cycle id_stall = 1. It holds at 0xFFFFFFFF and is not cleared by flush.
- Watchdog: a consecutive-stall counter counts each stall cycle and is zeroed on any non-stall cycle. When it reaches STALL_LIMIT, deadlock is set. deadlock stays set until rst or flush.

## Timing
- Reset values: all cnt = 0, busy_vec = 0, stall_cnt = 0, deadlock = 0, watchdog counter = 0. id_stall and id_issue then follow their inputs combinationally.
- id_stall and id_issue are combinational from inputs and registered state, in the same cycle.
- The issue-to-busy latency is one cycle: busy_vec reflects an issue on the following edge.
- A dependent instruction presented in the cycle after a producer issues stalls until the cycle of the matching WB (inclusive bypass).
- deadlock asserts on the edge on which the STALL_LIMIT-th consecutive stall cycle completes. It is visible from the next cycle.
- rst asserted mid-operation clears all state on that edge regardless of other inputs.

## Test plan
- Reset, then issue writes to r5 -> busy_vec = 0x00000020 one cycle later. A reader of r5 stalls; WB r5 in the same cycle as the reader -> id_stall = 0, id_issue = 1, busy_vec = 0.
- Issue 3 writes to r7 without WB (CNT_W=2) -> cnt[7] = 3. A 4th writer to r7 stalls. One WB r7 in the same cycle still stalls; the writer issues on the following cycle.
- Writes/reads of r0 -> never stall, busy_vec[0] always 0. WB to an idle r9 -> cnt[9] stays 0.
- Same-cycle issue (write r3) and WB r3 with cnt[3] = 1 -> cnt[3] remains 1.
- Dependent reader held stalled for 64 cycles (STALL_LIMIT=64) -> stall_cnt = 64 and deadlock = 1 on the next cycle. Then flush -> busy_vec = 0, deadlock = 0, stall_cnt still 64.
- rst asserted while cnt[4] = 2 and id_stall = 1 -> next cycle all outputs are at reset values.
